// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch-stage control, instruction-memory and IF/ID bundle
interface pc_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
    input  imem_addr, pc_plus4, if_id_pc_plus4, if_id_instr, if_id_valid, fetch_count
  );
  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
    output imem_addr, pc_plus4, if_id_pc_plus4, if_id_instr, if_id_valid, fetch_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, next-PC select and IF/ID pipeline register
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  pc_fetch_unit_if.slave bus
);
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};
  typedef enum logic {BOOT, RUN} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;
  logic        run, redirect;
  assign pc_plus4           = pc_q + 32'd4;
  assign run                = state_q == RUN;
  assign redirect           = bus.jump | bus.branch_taken;
  assign bus.imem_addr      = pc_q;
  assign bus.pc_plus4       = pc_plus4;
  assign bus.if_id_pc_plus4 = if_pc4_q;
  assign bus.if_id_instr    = if_instr_q;
  assign bus.if_id_valid    = if_valid_q;
  assign bus.fetch_count    = cnt_q;
  // next PC and IF/ID: jump > branch > stall > sequential fetch; BOOT holds everything
  always_comb begin
    state_d    = RUN;
    pc_d       = pc_q;
    if_pc4_d   = if_pc4_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    cnt_d      = cnt_q;
    if (run && redirect) begin
      pc_d       = bus.jump ? {bus.jump_target[31:2], 2'b00} : {bus.branch_target[31:2], 2'b00};
      if_pc4_d   = 32'd0;
      if_instr_d = NOP_INSTR;
      if_valid_d = 1'b0;
    end else if (run && !bus.stall) begin
      pc_d       = pc_plus4;
      if_pc4_d   = pc_plus4;
      if_instr_d = bus.imem_rdata;
      if_valid_d = 1'b1;
      cnt_d      = cnt_q + 32'd1;
    end
  end
  // state registers with synchronous reset discarding any in-flight IF/ID content
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC_A;
      if_pc4_q   <= 32'd0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc4_q   <= if_pc4_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scoreboard bench for the fetch stage
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  pc_fetch_unit_if bus ();
  pc_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_rdata = 32'hA000_0000 | bus.imem_addr;
  typedef struct {
    string       tag;
    logic [31:0] a, p, ip, ins;
    logic        v;
    logic [31:0] c;
  } exp_t;
  exp_t sb[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic st,
                      input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic [31:0] a, input logic [31:0] p,
                      input logic [31:0] ip, input logic [31:0] ins,
                      input logic v, input logic [31:0] c);
    exp_t e;
    rst = r;
    bus.stall = st;
    bus.branch_taken = br;
    bus.branch_target = bt;
    bus.jump = j;
    bus.jump_target = jt;
    sb.push_back('{tag, a, p, ip, ins, v, c});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, " imem_addr"}, bus.imem_addr, e.a);
    chk({e.tag, " pc_plus4"}, bus.pc_plus4, e.p);
    chk({e.tag, " if_id_pc_plus4"}, bus.if_id_pc_plus4, e.ip);
    chk({e.tag, " if_id_instr"}, bus.if_id_instr, e.ins);
    chk({e.tag, " if_id_valid"}, {31'd0, bus.if_id_valid}, {31'd0, e.v});
    chk({e.tag, " fetch_count"}, bus.fetch_count, e.c);
  endtask
  initial begin
    step("reset",    1, 0, 0, 0,     0, 0,     32'h0,  32'h4,  32'h0,  32'h0,         0, 0);
    step("boot",     0, 0, 0, 0,     0, 0,     32'h0,  32'h4,  32'h0,  32'h0,         0, 0);
    step("fetch0",   0, 0, 0, 0,     0, 0,     32'h4,  32'h8,  32'h4,  32'hA000_0000, 1, 1);
    step("fetch1",   0, 0, 0, 0,     0, 0,     32'h8,  32'hC,  32'h8,  32'hA000_0004, 1, 2);
    step("stall1",   0, 1, 0, 0,     0, 0,     32'h8,  32'hC,  32'h8,  32'hA000_0004, 1, 2);
    step("stall2",   0, 1, 0, 0,     0, 0,     32'h8,  32'hC,  32'h8,  32'hA000_0004, 1, 2);
    step("stall3",   0, 1, 0, 0,     0, 0,     32'h8,  32'hC,  32'h8,  32'hA000_0004, 1, 2);
    step("resume",   0, 0, 0, 0,     0, 0,     32'hC,  32'h10, 32'hC,  32'hA000_0008, 1, 3);
    step("fetch3",   0, 0, 0, 0,     0, 0,     32'h10, 32'h14, 32'h10, 32'hA000_000C, 1, 4);
    step("branch",   0, 0, 1, 32'h43, 0, 0,    32'h40, 32'h44, 32'h0,  32'h0,         0, 4);
    step("br_tgt",   0, 0, 0, 0,     0, 0,     32'h44, 32'h48, 32'h44, 32'hA000_0040, 1, 5);
    step("all3",     0, 1, 1, 32'h200, 1, 32'h100, 32'h100, 32'h104, 32'h0, 32'h0,   0, 5);
    step("jmp_tgt",  0, 0, 0, 0,     0, 0,     32'h104, 32'h108, 32'h104, 32'hA000_0100, 1, 6);
    step("jmp_top",  0, 0, 0, 0,     1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 6);
    step("wrap",     0, 0, 0, 0,     0, 0,     32'h0,  32'h4,  32'h0,  32'hFFFF_FFFC, 1, 7);
    step("jmp20",    0, 0, 0, 0,     1, 32'h20, 32'h20, 32'h24, 32'h0, 32'h0,         0, 7);
    step("rst_stall",1, 1, 0, 0,     0, 0,     32'h0,  32'h4,  32'h0,  32'h0,         0, 0);
    step("boot_ign", 0, 1, 1, 32'h200, 1, 32'h300, 32'h0, 32'h4, 32'h0, 32'h0,        0, 0);
    step("post_rst", 0, 0, 0, 0,     0, 0,     32'h4,  32'h8,  32'h4,  32'hA000_0000, 1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage register block: holds the program counter, forms PC+4, selects the next PC (sequential, branch, jump) and captures the fetched instruction into the IF/ID pipeline register. It drives the instruction-memory address and the PC+4 adder input. It feeds the decode stage with a valid-tagged {PC+4, instruction} pair. Stall and redirect arrive from later stages; there is no hazard detection inside the block.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- NOP_INSTR, 32'h0000_0000, instruction value placed in IF/ID when empty or flushed
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID contents this cycle
- branch_taken  in  1  redirect to branch_target
- branch_target  in  32  branch destination
- jump  in  1  redirect to jump_target
- jump_target  in  32  jump destination
- imem_addr  out  32  current PC, combinational from PC register
- imem_rdata  in  32  instruction at imem_addr, combinational (same cycle)
- pc_plus4  out  32  current PC + 4, combinational
- if_id_pc_plus4  out  32  registered PC+4 of captured instruction
- if_id_instr  out  32  registered instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- fetch_count  out  32  count of instructions captured valid into IF/ID

## Operation
- State: pc (32), IF/ID {pc_plus4, instr, valid}, fetch_count, 2-state FSM BOOT/RUN.
- BOOT: entered on rst; lasts exactly one cycle; PC not advanced, IF/ID stays invalid; next state RUN unconditionally (stall, redirect ignored in BOOT).
- RUN, per rising edge, priority highest first:
  - jump=1: pc <= {jump_target[31:2],2'b00}; IF/ID <= {0, NOP_INSTR, 0}.
  - branch_taken=1: pc <= {branch_target[31:2],2'b00}; IF/ID flushed as above.
  - stall=1: pc, IF/ID, fetch_count hold.
  - else: pc <= pc+4; IF/ID <= {pc+4, imem_rdata, 1}; fetch_count += 1.
- Redirect beats stall when both asserted in the same cycle.
- jump and branch_taken together: jump wins.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- fetch_count wraps at 2^32 silently.
- Target low bits [1:0] always forced to 0; RESET_PC likewise masked.

## Timing
- Reset values (cycle after rst sampled high): pc = RESET_PC, imem_addr = RESET_PC, pc_plus4 = RESET_PC+4, if_id_pc_plus4 = 0, if_id_instr = NOP_INSTR, if_id_valid = 0, fetch_count = 0, FSM = BOOT.
- rst asserted mid-operation overrides all inputs at that edge; any in-flight IF/ID content is discarded.
- imem_addr and pc_plus4 change only at rising edges (combinational from pc only).
- Fetch-to-decode latency: 1 cycle; instruction at PC P appears in IF/ID the edge after it is presented, with if_id_pc_plus4 = P+4.
- Redirect latency: target on imem_addr 1 cycle after redirect sampled; its instruction valid in IF/ID 2 cycles after.
- Stall held N cycles: outputs frozen N cycles, then resume with no instruction lost or duplicated.
- First valid IF/ID after reset deasserts: 2 edges (BOOT edge, then first RUN capture of RESET_PC).

## Test plan
- Reset then free-run, imem_rdata = 32'hA000_0000|addr: IF/ID valid from 2nd edge; if_id_pc_plus4 sequence 4, 8, 12; fetch_count 1, 2, 3.
- Stall 3 cycles at pc=8: imem_addr stays 8, IF/ID holds {8, 32'hA000_0004, 1}; after release next capture {12, 32'hA000_0008}, count continues without gap.
- branch_taken with branch_target=32'h0000_0043 at pc=16: next imem_addr = 32'h40, if_id_valid = 0 one cycle, then {32'h44, 32'hA000_0040, 1}.
- jump (target 32'h100), branch_taken (target 32'h200) and stall all high same cycle: imem_addr = 32'h100, IF/ID flushed.
- Wrap: jump to 32'hFFFF_FFFC: pc_plus4 = 0; next edge imem_addr = 0, if_id_pc_plus4 = 0, valid = 1.
- rst high during stall at pc=32'h20: next cycle pc = RESET_PC, if_id_valid = 0, fetch_count = 0, FSM BOOT.
